// File: rtl/stream_to_mem_writer.sv
// stream_to_mem_writer: Avalon-ST sink that writes one packet of 32-bit words
// into a single-port on-chip memory through an Avalon-MM write master port.
// A start pulse arms the block; word_count/done/overflow report the result.
module stream_to_mem_writer #(
  parameter int DEPTH  = 65000,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   max_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [1:0]        in_empty,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  // Address sum is two bits wider than the word address so base + count can
  // never wrap silently; anything at or above DEPTH is out of range.
  localparam int               SUM_W     = ADDR_W + 2;
  localparam logic [SUM_W-1:0] DEPTH_LIM = SUM_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   max_q;
  logic [SUM_W-1:0]  wr_addr;
  logic              start_ok;
  logic              take;
  logic              room;
  logic              do_write;
  logic              trunc;

  // A start is honoured only when no packet is in flight.
  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  // Beats that belong to the packet: everything in WRITE, only sop in ARMED.
  assign take     = in_valid && in_ready && (state == S_WRITE || in_sop);
  assign wr_addr  = SUM_W'(base_q) + SUM_W'(word_count);
  assign room     = (word_count < max_q) && (wr_addr < DEPTH_LIM);
  assign do_write = take && room;
  assign trunc    = take && !room;

  assign mem_chipselect = mem_write;
  assign mem_clken      = 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_sop) state_nxt = in_eop ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_eop) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_ARMED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-packet configuration captured on an accepted start.
  always_ff @(posedge clk) begin
    // NOTE: these registers carry no reset; they are only consulted after a
    // start has loaded them, so a reset value would be dead logic.
    if (start_ok) begin
      base_q <= base_addr;
      max_q  <= (max_words == '0) ? (ADDR_W+1)'(1) : max_words;
    end
  end

  // Memory write port, word counter and truncation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= 4'b0000;
      word_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      mem_write <= do_write;
      if (do_write) begin
        mem_address    <= wr_addr[ADDR_W-1:0];
        mem_writedata  <= in_data;
        mem_byteenable <= in_eop ? (4'b1111 << in_empty) : 4'b1111;
        word_count     <= word_count + 1'b1;
      end
      if (trunc) overflow <= 1'b1;
      if (start_ok) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_to_mem_writer.sv
// Self-checking bench for stream_to_mem_writer: directed packets from the
// test plan plus randomized packets, checked against a per-beat model.
module tb_stream_to_mem_writer;

  localparam int DEPTH = 65000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] max_words;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_empty;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [16:0] word_count;

  stream_to_mem_writer #(.DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .max_words(max_words), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy),
    .done(done), .overflow(overflow), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [31:0] data;
  } beat_t;

  beat_t pkt[$];
  int    checks    = 0;
  int    failures  = 0;
  int    obs_writes = 0;

  // Count every memory write cycle, sampled mid-cycle.
  always @(negedge clk) if (mem_write && mem_chipselect) obs_writes++;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] be_for(logic eop, logic [1:0] empty);
    logic [3:0] tbl [4];
    tbl[0] = 4'b1111; tbl[1] = 4'b1110; tbl[2] = 4'b1100; tbl[3] = 4'b1000;
    return eop ? tbl[empty] : 4'b1111;
  endfunction

  // Build a packet: `garbage` non-sop beats, then `len` beats sop..eop.
  task automatic mk_pkt(int garbage, int len, logic [1:0] last_empty, bit fixed, logic [31:0] d0);
    beat_t b;
    pkt.delete();
    for (int i = 0; i < garbage; i++) begin
      b.sop = 1'b0; b.eop = 1'($urandom_range(0, 1));
      b.empty = 2'($urandom); b.data = $urandom;
      pkt.push_back(b);
    end
    for (int i = 0; i < len; i++) begin
      b.sop   = (i == 0);
      b.eop   = (i == len - 1);
      b.empty = (i == len - 1) ? last_empty : 2'($urandom);
      b.data  = fixed ? d0 + 32'(i) : $urandom;
      pkt.push_back(b);
    end
  endtask

  task automatic arm(logic [15:0] base, logic [16:0] maxw);
    base_addr = base; max_words = maxw; start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 16'($urandom); max_words = 17'($urandom);
    check("arm_busy", busy, 1);
    check("arm_ready", in_ready, 1);
    check("arm_wc", word_count, 0);
    check("arm_ovf", overflow, 0);
    check("arm_done", done, 0);
  endtask

  // Send up to send_n beats of pkt and check each against the model: beats
  // before the first sop are dropped; a packet beat is written at base+n while
  // n < limit and base+n < DEPTH, otherwise it only sets overflow.
  task automatic run_pkt(string tag, logic [15:0] base, logic [16:0] maxw, bit gaps, int send_n);
    int eff_max = (maxw == 0) ? 1 : int'(maxw);
    int n = 0;
    int w0 = obs_writes;
    bit seen = 0;
    bit ovf = 0;
    bit ended = 0;
    for (int i = 0; i < send_n; i++) begin
      int waited = 0;
      bit wr = 0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1; in_sop = pkt[i].sop; in_eop = pkt[i].eop;
      in_empty = pkt[i].empty; in_data = pkt[i].data;
      while (!in_ready && waited < 50) begin
        tick();
        waited++;
      end
      check($sformatf("%s_ready_b%0d", tag, i), in_ready, 1);
      if (!in_ready) begin
        in_valid = 1'b0;
        return;
      end
      tick();
      in_valid = 1'b0;
      if (seen || pkt[i].sop) begin
        seen = 1;
        if (n < eff_max && int'(base) + n < DEPTH) begin
          wr = 1;
          check($sformatf("%s_addr_b%0d", tag, i), mem_address, int'(base) + n);
          check($sformatf("%s_data_b%0d", tag, i), mem_writedata, pkt[i].data);
          check($sformatf("%s_be_b%0d", tag, i), mem_byteenable, be_for(pkt[i].eop, pkt[i].empty));
          n++;
        end else begin
          ovf = 1;
        end
      end
      check($sformatf("%s_wr_b%0d", tag, i), mem_write, wr);
      check($sformatf("%s_wc_b%0d", tag, i), word_count, n);
      check($sformatf("%s_ovf_b%0d", tag, i), overflow, ovf);
      if (seen && pkt[i].eop) begin
        ended = 1;
        check($sformatf("%s_done", tag), done, 1);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_ready_end", tag), in_ready, 0);
        break;
      end
    end
    if (ended) begin
      tick();
      check($sformatf("%s_nwrites", tag), obs_writes - w0, n);
      check($sformatf("%s_pulse", tag), mem_write, 0);
    end
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; base_addr = '0; max_words = '0;
    in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", in_ready, 0);
    check("rst_write", mem_write, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_wc", word_count, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_writedata, 0);
    check("rst_be", mem_byteenable, 0);
    check("rst_clken", mem_clken, 1);

    // Basic 4-beat packet; a start while armed must be ignored.
    arm(16'h0100, 17'd16);
    base_addr = 16'h7777; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ign", busy, 1);
    mk_pkt(0, 4, 2'd0, 1, 32'hA0);
    run_pkt("basic", 16'h0100, 17'd16, 0, pkt.size());

    // Partial last word, empty=3 then empty=1.
    arm(16'h0200, 17'd16);
    mk_pkt(0, 2, 2'd3, 0, 0);
    run_pkt("empty3", 16'h0200, 17'd16, 0, pkt.size());
    arm(16'h0210, 17'd16);
    mk_pkt(0, 2, 2'd1, 0, 0);
    run_pkt("empty1", 16'h0210, 17'd16, 1, pkt.size());

    // Pre-sop garbage then a single sop+eop beat.
    arm(16'h0300, 17'd8);
    mk_pkt(3, 1, 2'd0, 1, 32'h55);
    run_pkt("single", 16'h0300, 17'd8, 0, pkt.size());

    // Truncation by word limit.
    arm(16'h0400, 17'd3);
    mk_pkt(0, 6, 2'd0, 0, 0);
    run_pkt("trunc", 16'h0400, 17'd3, 0, pkt.size());

    // Address limit at the top of memory.
    arm(16'd64998, 17'd16);
    mk_pkt(0, 4, 2'd0, 0, 0);
    run_pkt("alimit", 16'd64998, 17'd16, 0, pkt.size());

    // A limit of 0 behaves as 1.
    arm(16'h0500, 17'd0);
    mk_pkt(0, 3, 2'd2, 0, 0);
    run_pkt("max0", 16'h0500, 17'd0, 0, pkt.size());

    // Reset mid-packet: beat 3 is presented with reset high and must be lost.
    arm(16'h2000, 17'd16);
    mk_pkt(0, 5, 2'd0, 0, 0);
    w0 = obs_writes;
    run_pkt("rstmid", 16'h2000, 17'd16, 0, 2);
    in_valid = 1'b1; in_sop = pkt[2].sop; in_eop = pkt[2].eop;
    in_empty = pkt[2].empty; in_data = pkt[2].data;
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("rstmid_write", mem_write, 0);
    check("rstmid_ready", in_ready, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_wc", word_count, 0);
    check("rstmid_nwrites", obs_writes - w0, 2);
    arm(16'h3000, 17'd8);
    mk_pkt(0, 3, 2'd0, 0, 0);
    run_pkt("restart", 16'h3000, 17'd8, 0, pkt.size());

    // Randomized packets, some near the top of the address space.
    for (int k = 0; k < 12; k++) begin
      logic [15:0] b;
      logic [16:0] m;
      b = (k % 3 == 0) ? 16'($urandom_range(64990, 65535)) : 16'($urandom);
      m = 17'($urandom_range(0, 8));
      arm(b, m);
      mk_pkt($urandom_range(0, 2), $urandom_range(1, 8), 2'($urandom), 0, 0);
      run_pkt($sformatf("rnd%0d", k), b, m, 1, pkt.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_to_mem_writer.md
# stream_to_mem_writer

Avalon-ST sink to Avalon-MM write master that captures one packet of 32-bit words into the main on-chip memory (single-port, 32-bit, 16-bit word address, byte enables, no waitrequest). It sits directly upstream of the main memory and drives its `address`/`byteenable`/`chipselect`/`write`/`writedata`/`clken` inputs, one word per accepted beat. A start pulse arms the block, and status outputs report the word count, completion and truncation.

## Interface
- `DEPTH`, 65000: number of valid memory words; legal addresses are 0..DEPTH-1.
- `ADDR_W`, 16: word-address width.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle arm pulse; ignored unless state is IDLE or DONE.
- `base_addr` in 16: first word address; sampled on an accepted `start`.
- `max_words` in 17: word limit, 1..65536; sampled on an accepted `start`. A value of 0 is treated as 1.
- `in_valid`, `in_ready` in/out 1: Avalon-ST handshake. A beat transfers when both are high.
- `in_data` in 32: beat data. The first byte of the beat is in [31:24].
- `in_sop`, `in_eop` in 1: packet delimiters.
- `in_empty` in 2: unused byte count; meaningful only when `in_eop` is high.
- `mem_address` out 16, `mem_byteenable` out 4, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out 32, `mem_clken` out 1: memory master port.
- `busy` out 1: high in ARMED and WRITE.
- `done` out 1: high in DONE.
- `overflow` out 1: the packet was truncated.
- `word_count` out 17: number of words written to memory.

## Operation
- States:
  - IDLE: `in_ready`=0.
  - ARMED: `in_ready`=1. Beats without `in_sop` are discarded.
  - WRITE: `in_ready`=1.
  - DONE: `in_ready`=0.
- Transitions:
  - IDLE/DONE + `start` → ARMED. This clears `word_count` and `overflow` and latches `base_addr` and `max_words`.
  - ARMED + accepted beat with `in_sop` → WRITE. The beat is written. If that beat also carries `in_eop`, the next state is DONE instead.
  - WRITE + accepted `in_eop` → DONE.
  - Any state + `reset` → IDLE.
- Write rule:
  - An accepted beat in WRITE, or an sop beat in ARMED, is registered into the memory port.
  - Address = latched base + `word_count`, 16-bit.
  - Byteenable = 4'b1111, except on an eop beat, where empty 0/1/2/3 → 1111/1110/1100/1000.
- `in_sop` seen while in WRITE is treated as an ordinary data beat (no restart).
- Truncation: a beat is not written when either of these holds:
  - `word_count` = latched `max_words`, or
  - computed address ≥ DEPTH (including a 16-bit wrap past 65535).
  
  In that case `overflow` is set and held. The block keeps `in_ready`=1 and discards beats until eop; the eop beat still moves the state to DONE.
- `mem_chipselect` = `mem_write` (write-only master). `mem_clken` is tied to 1.
- `word_count` increments by 1 for each word actually written and saturates at `max_words`.

## Timing
- Reset values:
  - `in_ready`, `mem_write`, `mem_chipselect`, `busy`, `done`, `overflow` = 0.
  - `word_count`, `mem_address`, `mem_writedata` = 0.
  - `mem_byteenable` = 4'b0000.
  - `mem_clken` = 1.
- `start` at edge N → `busy`=1 and `in_ready`=1 from cycle N+1.
- Beat accepted at edge N → `mem_write`=1 with address/data/byteenable during cycle N+1, written at edge N+1. Write latency is 1 cycle.
- `mem_write` is a single-cycle pulse per beat. Back-to-back beats produce back-to-back writes at 1 word/cycle.
- `word_count` updates at the same edge the write is registered, so it reads as the new value in cycle N+1.
- Accepted eop at edge N → `done`=1 and `busy`=0 in cycle N+1, while the final `mem_write` is also in cycle N+1. `in_ready`=0 from cycle N+1.
- `start` in the same cycle as an accepted beat: not possible, because `in_ready`=0 whenever `start` is honoured.
- `start` while busy: ignored.
- `reset` asserted mid-packet: at the next edge, state → IDLE and `mem_write`=0. Any write registered in that cycle is dropped.

## Test plan
- Basic 4-beat packet:
  - Stimulus: base=0x0100, max=16; 4 beats sop..eop with data 0xA0..0xA3, empty=0.
  - Required: writes to 0x0100..0x0103, byteenable 1111 each; `word_count`=4; `done`=1 one cycle after eop; `overflow`=0.
- Partial last word:
  - Stimulus: 2-beat packet, eop beat with empty=3.
  - Required: second write has byteenable 1000; empty=1 gives 1110.
- Pre-sop garbage and single-beat packet:
  - Stimulus: 3 beats without sop while ARMED, then one beat with sop and eop (0x55).
  - Required: exactly one write, to base; `word_count`=1.
- Truncation:
  - Stimulus: max=3, 6-beat packet.
  - Required: 3 writes; `overflow`=1; beats 4..6 accepted but not written; DONE after beat 6.
- Address limit:
  - Stimulus: base=64998, 4 beats.
  - Required: writes at 64998 and 64999 only; `overflow`=1; `word_count`=2.
- Reset and restart:
  - Stimulus: `reset` asserted on the cycle after the 2nd beat of a 5-beat packet.
  - Required: state IDLE and `mem_write`=0 next cycle. A new `start` then writes a fresh packet from the new base with `word_count` starting at 0.
